// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one pipelined main memory between the I-side fetch-miss
// requester and the D-side load-miss/store requester of the 5-stage CPU.
// Misses are serviced as WORDS-word block fills and stores as single-word
// writes. A one-cycle done pulse goes to the granted side when the transaction
// completes. When both sides request at once, the grant alternates.
//
// Ports:
//   clk, rst                    clock (rising edge), async active-high reset
//   i_req, i_addr               I-side fill request (level) and miss byte address
//   i_fill_valid/idx/data       I-side fill word stream
//   i_done                      I-side completion pulse
//   d_req, d_wr, d_addr,        D-side request (level), write select
//   d_wdata                     (sampled at grant), byte address, write data
//   d_fill_valid/idx/data       D-side fill word stream
//   d_done                      D-side completion pulse
//   mem_enable, mem_wr,         memory command: access strobe, write select,
//   mem_addr, mem_data_out      byte address (bit0 = 0), write data
//   mem_data_in, mem_data_valid memory read return (in order, fixed latency)
//   busy                        a transaction is in progress
module mem_arbiter #(
  parameter int unsigned WORDS  = 8,
  parameter int unsigned ADDR_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_req,
  input  logic [ADDR_W-1:0]          i_addr,
  output logic                       i_fill_valid,
  output logic [$clog2(WORDS)-1:0]   i_fill_idx,
  output logic [15:0]                i_fill_data,
  output logic                       i_done,
  input  logic                       d_req,
  input  logic                       d_wr,
  input  logic [ADDR_W-1:0]          d_addr,
  input  logic [15:0]                d_wdata,
  output logic                       d_fill_valid,
  output logic [$clog2(WORDS)-1:0]   d_fill_idx,
  output logic [15:0]                d_fill_data,
  output logic                       d_done,
  output logic                       mem_enable,
  output logic                       mem_wr,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [15:0]                mem_data_out,
  input  logic [15:0]                mem_data_in,
  input  logic                       mem_data_valid,
  output logic                       busy
);

  localparam int unsigned IDX_W = $clog2(WORDS);
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0]  WORDS_C   = CNT_W'(WORDS);
  localparam logic [CNT_W-1:0]  LAST_C    = CNT_W'(WORDS - 1);
  localparam logic [ADDR_W-1:0] BLK_MASK  = ADDR_W'(2 * WORDS - 1);

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  state_t              state, state_nx;
  logic                side_q;      // 1 = D-side owns the current transaction
  logic                last_d_q;    // 1 = most recent completed grant was D
  logic [ADDR_W-1:0]   addr_q;
  logic [15:0]         wdata_q;
  logic [CNT_W-1:0]    k_q;         // fill issue count
  logic [CNT_W-1:0]    r_q;         // fill return count
  logic                grant;
  logic                grant_d;
  logic [ADDR_W-1:0]   base;

  // D wins when alone, or on a tie when I was served last.
  assign grant   = i_req | d_req;
  assign grant_d = d_req & (~i_req | ~last_d_q);
  assign base    = addr_q & ~BLK_MASK;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      side_q   <= 1'b0;
      last_d_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      k_q      <= '0;
      r_q      <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (grant) begin
            side_q  <= grant_d;
            addr_q  <= grant_d ? d_addr : i_addr;
            wdata_q <= d_wdata;
            k_q     <= '0;
            r_q     <= '0;
          end
        end
        FILL: begin
          if (k_q != WORDS_C) k_q <= k_q + 1'b1;
          if (mem_data_valid) r_q <= r_q + 1'b1;
        end
        DONE: last_d_q <= side_q;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx     = state;
    i_fill_valid = 1'b0;
    i_fill_idx   = '0;
    i_fill_data  = '0;
    i_done       = 1'b0;
    d_fill_valid = 1'b0;
    d_fill_idx   = '0;
    d_fill_data  = '0;
    d_done       = 1'b0;
    mem_enable   = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_data_out = '0;
    busy         = (state != IDLE);
    case (state)
      IDLE: begin
        if (grant) state_nx = (grant_d && d_wr) ? WRITE : FILL;
      end
      FILL: begin
        if (k_q != WORDS_C) begin
          mem_enable = 1'b1;
          mem_addr   = base + ADDR_W'({k_q, 1'b0});
        end
        if (mem_data_valid) begin
          // Fill data is gated by valid so every output is 0 outside a return.
          if (side_q) begin
            d_fill_valid = 1'b1;
            d_fill_idx   = r_q[IDX_W-1:0];
            d_fill_data  = mem_data_in;
          end else begin
            i_fill_valid = 1'b1;
            i_fill_idx   = r_q[IDX_W-1:0];
            i_fill_data  = mem_data_in;
          end
          if (r_q == LAST_C) state_nx = DONE;
        end
      end
      WRITE: begin
        mem_enable   = 1'b1;
        mem_wr       = 1'b1;
        mem_addr     = {addr_q[ADDR_W-1:1], 1'b0};
        mem_data_out = wdata_q;
        state_nx     = DONE;
      end
      DONE: begin
        if (side_q) d_done = 1'b1;
        else        i_done = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: latency-4 pipelined memory model, scoreboard of
// expected memory issues, fill words and done pulses, a table of single
// transactions, and hand sequences for arbitration, reset and stray returns.
module tb_mem_arbiter;
  localparam int WORDS = 8;
  localparam int L     = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0, d_req = 1'b0, d_wr = 1'b0;
  logic [15:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic        i_fill_valid, d_fill_valid, i_done, d_done;
  logic [2:0]  i_fill_idx, d_fill_idx;
  logic [15:0] i_fill_data, d_fill_data;
  logic        mem_enable, mem_wr, busy;
  logic [15:0] mem_addr, mem_data_out, mem_data_in;
  logic        mem_data_valid;
  logic        inject = 1'b0;

  mem_arbiter #(.WORDS(8), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_fill_valid(i_fill_valid),
    .i_fill_idx(i_fill_idx), .i_fill_data(i_fill_data), .i_done(i_done),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_fill_valid(d_fill_valid), .d_fill_idx(d_fill_idx),
    .d_fill_data(d_fill_data), .d_done(d_done),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_data_out(mem_data_out), .mem_data_in(mem_data_in),
    .mem_data_valid(mem_data_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return (a ^ 16'h5A3C) + 16'h0101;
  endfunction

  // Memory: read issued in cycle c returns valid in cycle c+L; not reset.
  logic [L-1:0] pv = '0;
  logic [15:0]  pd [L] = '{default: 16'h0};
  always @(posedge clk) begin
    pv    <= {pv[L-2:0], mem_enable & ~mem_wr};
    pd[0] <= mem_fn(mem_addr);
    for (int i = 1; i < L; i++) pd[i] <= pd[i-1];
  end
  assign mem_data_valid = pv[L-1] | inject;
  assign mem_data_in    = inject ? 16'h1111 : pd[L-1];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name, input logic [15:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %0h expected nothing (t=%0t)", name, act, $time);
  endtask

  typedef struct { logic [15:0] addr; logic wr; logic [15:0] data; } issue_t;
  typedef struct { logic side; logic [2:0] idx; logic [15:0] data; } fill_t;
  issue_t issue_q[$];
  fill_t  fill_q[$];
  logic   done_q[$];

  logic   mon_en = 1'b0;
  issue_t m_it;
  fill_t  m_ft;
  logic   m_ds;

  always @(negedge clk) begin
    if (mon_en) begin
      if (mem_enable) begin
        if (issue_q.size() == 0) flag("unexpected_issue", mem_addr);
        else begin
          m_it = issue_q.pop_front();
          check("mem_addr", mem_addr, m_it.addr);
          check("mem_wr", mem_wr, m_it.wr);
          check("mem_data_out", mem_data_out, m_it.data);
        end
      end else begin
        check("noissue_wr_dout", {mem_wr, mem_data_out}, '0);
      end
      check("fill_exclusive", i_fill_valid & d_fill_valid, 0);
      if (i_fill_valid | d_fill_valid) begin
        if (fill_q.size() == 0) flag("unexpected_fill", d_fill_valid ? d_fill_data : i_fill_data);
        else begin
          m_ft = fill_q.pop_front();
          check("fill_side", d_fill_valid, m_ft.side);
          check("fill_idx", d_fill_valid ? d_fill_idx : i_fill_idx, m_ft.idx);
          check("fill_data", d_fill_valid ? d_fill_data : i_fill_data, m_ft.data);
        end
      end
      if (i_done | d_done) begin
        check("done_exclusive", i_done & d_done, 0);
        if (done_q.size() == 0) flag("unexpected_done", {15'h0, d_done});
        else begin
          m_ds = done_q.pop_front();
          check("done_side", d_done, m_ds);
        end
      end
    end
  end

  task automatic push_txn(input logic is_fill, input logic side, input logic [15:0] a,
                          input logic [15:0] wd);
    if (is_fill) begin
      for (int i = 0; i < WORDS; i++) begin
        issue_q.push_back('{addr: a + 16'(2 * i), wr: 1'b0, data: 16'h0});
        fill_q.push_back('{side: side, idx: 3'(i), data: mem_fn(a + 16'(2 * i))});
      end
    end else begin
      issue_q.push_back('{addr: a, wr: 1'b1, data: wd});
    end
    done_q.push_back(side);
  endtask

  typedef struct {
    logic        use_d;
    logic        d_wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        exp_fill;
    logic [15:0] exp_addr;  // fill base or write address
    int          exp_lat;
    int          inject_at; // cycle to force a stray mem_data_valid, 0 = none
  } vec_t;
  vec_t vecs[$];

  task automatic run_txn(input vec_t v);
    int  n;
    bit  seen;
    n = 0;
    seen = 0;
    push_txn(v.exp_fill, v.use_d, v.exp_addr, v.wdata);
    @(posedge clk); #1;
    d_wr    = v.d_wr;
    d_wdata = v.wdata;
    if (v.use_d) begin d_req = 1'b1; d_addr = v.addr; i_addr = 16'h3333; end
    else         begin i_req = 1'b1; i_addr = v.addr; d_addr = 16'h7777; end
    while (!seen && n < 60) begin
      @(posedge clk); #1;
      n++;
      inject = (n == v.inject_at);
      @(negedge clk);
      if (i_done | d_done) seen = 1;
    end
    @(posedge clk); #1;
    inject = 1'b0;
    i_req  = 1'b0;
    d_req  = 1'b0;
    if (!seen) flag("done_timeout", v.addr);
    else check("latency", n, v.exp_lat);
    @(negedge clk);
    check("busy_after_done", busy, 0);
  endtask

  initial begin
    int  dones;
    int  late;
    int  n;
    vec_t pv5;

    vecs.push_back('{1'b1, 1'b0, 16'h1236, 16'h0000, 1'b1, 16'h1230, 13, 0});
    vecs.push_back('{1'b1, 1'b1, 16'h0043, 16'hBEEF, 1'b0, 16'h0042, 2, 1});
    vecs.push_back('{1'b0, 1'b0, 16'hFFF4, 16'h0000, 1'b1, 16'hFFF0, 13, 0});
    vecs.push_back('{1'b0, 1'b1, 16'h5555, 16'h9999, 1'b1, 16'h5550, 13, 0});
    vecs.push_back('{1'b1, 1'b0, 16'hABCF, 16'h0000, 1'b1, 16'hABC0, 13, 0});
    vecs.push_back('{1'b1, 1'b1, 16'hFFFF, 16'h1234, 1'b0, 16'hFFFE, 2, 0});
    vecs.push_back('{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000, 13, 0});

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {i_fill_valid, i_fill_idx, i_fill_data, i_done, d_fill_valid,
          d_fill_idx, d_fill_data, d_done, mem_enable, mem_wr, mem_addr, mem_data_out, busy}, '0);
    rst = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Simultaneous requests after reset: D first, then alternate D,I,D,I
    push_txn(1'b0, 1'b1, 16'h2000, 16'hAAAA);
    push_txn(1'b1, 1'b0, 16'h4000, 16'h0000);
    push_txn(1'b0, 1'b1, 16'h2000, 16'hAAAA);
    push_txn(1'b1, 1'b0, 16'h4000, 16'h0000);
    d_wr = 1'b1; d_addr = 16'h2001; d_wdata = 16'hAAAA; i_addr = 16'h4008;
    i_req = 1'b1; d_req = 1'b1;
    dones = 0;
    n = 0;
    while (dones < 4 && n < 200) begin
      @(negedge clk);
      n++;
      if (i_done | d_done) dones++;
      if (dones < 4) @(posedge clk);
    end
    @(posedge clk); #1;
    i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
    check("rr_done_count", dones, 4);

    // Stray return while idle must be ignored
    @(posedge clk); #1;
    inject = 1'b1;
    @(negedge clk);
    check("idle_inject_no_fill", {i_fill_valid, d_fill_valid}, 0);
    check("idle_inject_busy", busy, 0);
    @(posedge clk); #1;
    inject = 1'b0;

    foreach (vecs[i]) run_txn(vecs[i]);

    // Reset in the middle of a fill
    mon_en = 1'b0;
    @(posedge clk); #1;
    d_wr = 1'b0; d_addr = 16'h3014; d_req = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("pre_reset_issue", {mem_enable, mem_addr}, {1'b1, 16'h3018});
    @(posedge clk); #1;
    rst = 1'b1; d_req = 1'b0;
    #1;
    check("midfill_reset_outputs", {i_fill_valid, i_fill_idx, i_fill_data, i_done, d_fill_valid,
          d_fill_idx, d_fill_data, d_done, mem_enable, mem_wr, mem_addr, mem_data_out, busy}, '0);
    late = 0;
    @(negedge clk);
    if (mem_data_valid) late++;
    check("late_return_ignored", {i_fill_valid, d_fill_valid, d_done}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (mem_data_valid) late++;
      check("late_return_ignored", {i_fill_valid, d_fill_valid, d_done, busy}, 0);
    end
    check("late_return_count", late, 4);
    mon_en = 1'b1;
    pv5 = '{1'b1, 1'b0, 16'h3014, 16'h0000, 1'b1, 16'h3010, 13, 0};
    run_txn(pv5);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", issue_q.size() + fill_q.size() + done_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
